sum_uart_tx: RTL and testbench

- Downstream consumer of the dual 4-bit latch stage.
- Takes the two latched nibbles (q_a, q_b), adds them on a user send request, and transmits the 5-bit sum, zero-extended to one byte, as a UART 8N1 frame on a single tx pin.
- Provides the "Sum" and "UART" halves of the latch/sum/UART chain; drives the top-level outputs.

---
 rtl/sum_uart_pkg.sv | 23 ++
 rtl/uart_baud_counter.sv | 30 +++
 rtl/sum_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_sum_uart_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sum_uart_pkg.sv
// Shared state encoding and frame constants for sum_uart_tx.
// The effective frame length follows the UART_PARITY_EN macro.
package sum_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int UART_DATA_BITS       = 8;
  localparam int FRAME_BITS_NO_PARITY = 1 + UART_DATA_BITS + 1;
  localparam int FRAME_BITS_PARITY    = FRAME_BITS_NO_PARITY + 1;

`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
  localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done on the last count of each bit period.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign bit_done = enable && (count == LAST);

endmodule

// File: rtl/sum_uart_tx.sv
// Adds two latched nibbles on a send request and ships the zero-extended sum
// as one UART frame (8N1, or 8E1 when UART_PARITY_EN is defined).
//
// Handshake: send is an asynchronous level with no ready; one rising edge
// requests one frame, and busy marks the frame in flight. Requests seen while
// busy are dropped, so the producer should wait for busy low before re-arming.
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_W       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              send,
  output logic              tx,
  output logic              busy,
  output logic [DATA_W:0]   sum_out,
  output state_t            fsm_state
);

  localparam int BIT_IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(UART_DATA_BITS - 1);

  logic s1, s2, s3;
  logic send_event;

  state_t                    state, state_next;
  logic [UART_DATA_BITS-1:0] shreg, shreg_next;
  logic [BIT_IDX_W-1:0]      bit_idx, bit_idx_next;
  logic                      tx_next, busy_next;
  logic [DATA_W:0]           sum, sum_next;
  logic [UART_DATA_BITS-1:0] sum_byte;
  logic                      baud_clear, baud_enable, bit_done;
`ifdef UART_PARITY_EN
  logic                      parity, parity_next;
`endif

  // s3 remembers the previous synchronised level so a held send fires once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= send;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign send_event = s2 & ~s3;

  assign sum = {1'b0, operand_a} + {1'b0, operand_b};

  always_comb begin
    sum_byte            = '0;
    sum_byte[DATA_W:0]  = sum;
  end

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (baud_clear),
    .enable   (baud_enable),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      sum_out <= '0;
`ifdef UART_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
      busy    <= busy_next;
      sum_out <= sum_next;
`ifdef UART_PARITY_EN
      parity  <= parity_next;
`endif
    end
  end

  // tx is computed one edge ahead so every line transition is registered.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    tx_next      = tx;
    busy_next    = busy;
    sum_next     = sum_out;
    baud_clear   = 1'b0;
    baud_enable  = (state != IDLE);
`ifdef UART_PARITY_EN
    parity_next  = parity;
`endif

    case (state)
      IDLE: begin
        if (send_event) begin
          state_next   = START;
          shreg_next   = sum_byte;
          sum_next     = sum;
          bit_idx_next = '0;
          tx_next      = 1'b0;
          busy_next    = 1'b1;
          baud_clear   = 1'b1;
`ifdef UART_PARITY_EN
          parity_next  = ^sum_byte;
`endif
        end
      end

      START: begin
        if (bit_done) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = shreg[0];
        end
      end

      DATA: begin
        if (bit_done) begin
          if (bit_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            state_next = PARITY;
            tx_next    = parity;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            shreg_next   = shreg >> 1;
            tx_next      = shreg[1];
          end
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed bench for sum_uart_tx with CLKS_PER_BIT=4: a vector table of
// operand pairs plus hand-written reset, busy-drop and back-to-back sequences.
module tb_sum_uart_tx;
  import sum_uart_pkg::*;

  localparam int CPB = 4;
  localparam int DW  = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   exp_sum;
    logic [7:0]    frame_byte;
    logic          exp_par;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          send = 1'b0;
  logic [DW-1:0] operand_a = '0;
  logic [DW-1:0] operand_b = '0;
  logic          tx;
  logic          busy;
  logic [DW:0]   sum_out;
  state_t        fsm_state;

  int tests_run = 0;
  int tests_failed = 0;
  vec_t vecs[6];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  sum_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .send      (send),
    .tx        (tx),
    .busy      (busy),
    .sum_out   (sum_out),
    .fsm_state (fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard for one frame. Entered on the negedge where send (or reset
  // release) has just made the request; capture happens `lead` edges later.
  task automatic run_frame(input int lead, input logic [DW:0] exp_sum,
                           input logic [7:0] frame_byte, input logic exp_par,
                           input int pulse_cycle, input int rearm_cycle,
                           input string name);
    logic [0:0] exp_q[$];
    int busy_cycles;
    busy_cycles = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(frame_byte[i]);
    if (NBITS == FRAME_BITS_PARITY) exp_q.push_back(exp_par);
    exp_q.push_back(1'b1);

    for (int i = 1; i < lead; i++) begin
      @(negedge clk);
      check({name, "_pre_tx"}, tx, 1);
    end
    @(negedge clk);
    check({name, "_sum"}, sum_out, exp_sum);

    for (int c = 0; c < FRAME_CYC; c++) begin
      check($sformatf("%s_tx_c%0d", name, c), tx, exp_q[0]);
      if (c % CPB == CPB - 1) void'(exp_q.pop_front());
      if (busy) busy_cycles++;
      if (c == 1) send = 1'b0;
      if (c == pulse_cycle) begin
        send = 1'b1;
        operand_a = ~operand_a;
      end
      if (c == pulse_cycle + 1) send = 1'b0;
      if (c == rearm_cycle) send = 1'b1;
      @(negedge clk);
    end
    check({name, "_busy_len"}, busy_cycles, FRAME_CYC);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_tx_end"}, tx, 1);
    check({name, "_sum_hold"}, sum_out, exp_sum);
  endtask

  task automatic idle_check(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || !tx) bad++;
    end
    check({name, "_idle"}, bad, 0);
  endtask

  task automatic request(input logic [DW-1:0] a, input logic [DW-1:0] b);
    operand_a = a;
    operand_b = b;
    @(negedge clk);
    @(negedge clk);
    send = 1'b1;
  endtask

  initial begin
    vecs[0] = '{a: 4'd9,  b: 4'd7,  exp_sum: 5'd16, frame_byte: 8'h10, exp_par: 1'b1};
    vecs[1] = '{a: 4'd15, b: 4'd15, exp_sum: 5'd30, frame_byte: 8'h1E, exp_par: 1'b0};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  exp_sum: 5'd0,  frame_byte: 8'h00, exp_par: 1'b0};
    vecs[3] = '{a: 4'd10, b: 4'd5,  exp_sum: 5'd15, frame_byte: 8'h0F, exp_par: 1'b0};
    vecs[4] = '{a: 4'd3,  b: 4'd8,  exp_sum: 5'd11, frame_byte: 8'h0B, exp_par: 1'b1};
    vecs[5] = '{a: 4'd6,  b: 4'd1,  exp_sum: 5'd7,  frame_byte: 8'h07, exp_par: 1'b1};

    // Reset held with send high and nonzero operands
    reset_n = 1'b0;
    send = 1'b1;
    operand_a = 4'd5;
    operand_b = 4'd6;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst_tx_%0d", i), tx, 1);
      check($sformatf("rst_busy_%0d", i), busy, 0);
      check($sformatf("rst_sum_%0d", i), sum_out, 0);
    end
    check("rst_state", fsm_state, IDLE);
    reset_n = 1'b1;
    run_frame(3, 5'd11, 8'h0B, 1'b1, -1, -1, "rst_release");
    idle_check(20, "rst_one_frame");

    // Table of operand pairs
    for (int v = 0; v < 6; v++) begin
      request(vecs[v].a, vecs[v].b);
      run_frame(3, vecs[v].exp_sum, vecs[v].frame_byte, vecs[v].exp_par, -1, -1,
                $sformatf("vec%0d", v));
      idle_check(4, $sformatf("vec%0d", v));
    end

    // Second request mid-DATA with changed operands is dropped
    request(4'd9, 4'd7);
    run_frame(3, 5'd16, 8'h10, 1'b1, 10, -1, "busy_pulse");
    idle_check(24, "busy_drop");

    // Request landing in the first IDLE cycle starts a new frame at once
    request(4'd15, 4'd15);
    run_frame(3, 5'd30, 8'h1E, 1'b0, -1, FRAME_CYC - 2, "b2b_first");
    run_frame(1, 5'd30, 8'h1E, 1'b0, -1, -1, "b2b_second");
    idle_check(8, "b2b_after");

    // Asynchronous reset during data bit 3
    request(4'd9, 4'd7);
    repeat (3) @(negedge clk);
    send = 1'b0;
    repeat (17) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_sum", sum_out, 0);
    check("midrst_state", fsm_state, IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check(4, "midrst_quiet");
    request(4'd1, 4'd2);
    run_frame(3, 5'd3, 8'h03, 1'b0, -1, -1, "midrst_next");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
